// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq
//   Sequencer that evaluates a WIDTH-bit AND/OR/ADD/SUB/SLT operation by driving a single external
//   one-bit ALU slice once per cycle, LSB first, and collecting its outputs into a WIDTH-bit
//   result with carry/overflow/zero flags.
//
// Ports
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   start, op, operand_a/b       request; operands and op latched when start is seen in IDLE
//   busy                         high while an operation is in flight (RUN/FIX/DONE)
//   done                         one-cycle pulse, result and flags valid from this cycle
//   result, cout, overflow, zero result and flags, held until the next accepted start
//   alu_a/b/cin/less, alu_op     drive the external slice
//   alu_result/g/p/set           combinational outputs returned by the slice
module bit_serial_alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic             alu_less,
    output logic [2:0]       alu_op,
    input  logic             alu_result,
    input  logic             alu_g,
    input  logic             alu_p,
    input  logic             alu_set
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             cin_msb;
    logic             set_q;
    logic             carry_next;

    assign carry_next = alu_g | (alu_p & carry);
    assign busy       = (state != IDLE);
    assign alu_op     = op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        alu_a      = 1'b0;
        alu_b      = 1'b0;
        alu_cin    = 1'b0;
        alu_less   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                alu_a   = a_q[idx];
                alu_b   = b_q[idx];
                alu_cin = carry;
                if (idx == LAST_BIT) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cin_msb  <= 1'b0;
            set_q    <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // done is registered from the DONE state, so it lands in the cycle after DONE.
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        idx   <= '0;
                        carry <= op[2];
                    end
                end
                RUN: begin
                    result[idx] <= alu_result;
                    carry       <= carry_next;
                    idx         <= idx + 1'b1;
                    if (idx == LAST_BIT) begin
                        cin_msb <= carry;
                        set_q   <= alu_set;
                        cout    <= carry_next;
                    end
                end
                FIX: begin
                    overflow <= cin_msb ^ cout;
                    // SLT: the per-bit results were all "less = 0"; replace with the MSB sign.
                    if (op_q == OP_SLT) begin
                        result <= {{(WIDTH - 1){1'b0}}, set_q};
                    end
                end
                DONE: begin
                    zero <= (result == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq
//   Self-checking bench for bit_serial_alu_seq at WIDTH=8 with a behavioural one-bit ALU slice.
module tb_bit_serial_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       overflow;
    logic       zero;
    logic       alu_a;
    logic       alu_b;
    logic       alu_cin;
    logic       alu_less;
    logic [2:0] alu_op;
    logic       alu_result;
    logic       alu_g;
    logic       alu_p;
    logic       alu_set;

    int checks;
    int failures;

    bit_serial_alu_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .overflow   (overflow),
        .zero       (zero),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_less   (alu_less),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_g      (alu_g),
        .alu_p      (alu_p),
        .alu_set    (alu_set)
    );

    // One-bit ALU slice: op[2] inverts b, op[1:0] selects AND/OR/SUM/LESS.
    logic s_bb;
    logic s_sum;
    assign s_bb    = alu_b ^ alu_op[2];
    assign s_sum   = alu_a ^ s_bb ^ alu_cin;
    assign alu_g   = alu_a & s_bb;
    assign alu_p   = alu_a | s_bb;
    assign alu_set = s_sum;
    always_comb begin
        case (alu_op[1:0])
            2'b00:   alu_result = alu_a & s_bb;
            2'b01:   alu_result = alu_a | s_bb;
            2'b10:   alu_result = s_sum;
            default: alu_result = alu_less;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level reference: arithmetic on the whole operands.
    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic v, output logic z);
        logic [7:0] bi;
        logic [8:0] full;
        logic [7:0] low;
        bi   = o[2] ? ~b : b;
        full = {1'b0, a} + {1'b0, bi} + {8'd0, o[2]};
        low  = {1'b0, a[6:0]} + {1'b0, bi[6:0]} + {7'd0, o[2]};
        c    = full[8];
        v    = low[7] ^ full[8];
        case (o[1:0])
            2'b00:   r = a & bi;
            2'b01:   r = a | bi;
            2'b10:   r = full[7:0];
            default: r = (o == 3'b111) ? {7'd0, full[7]} : 8'h00;
        endcase
        z = (r == 8'h00);
    endtask

    // Issues one op and returns the number of edges from the accepting edge to done (bounded).
    task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0] o;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        logic       flags;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int lat2;
        logic [7:0] mr;
        logic mc, mv, mz;
        logic [2:0] ops[8];

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;

        vecs[0] = '{3'b010, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{3'b110, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3'b110, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{3'b111, 8'h05, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{3'b111, 8'h07, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, cout, overflow, zero}, 32'd0);
        chk("rst_alu_out", {25'd0, alu_a, alu_b, alu_cin, alu_less, alu_op}, 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].o, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 10);
            chk($sformatf("tbl%0d_result", i), {24'd0, result}, {24'd0, vecs[i].r});
            chk($sformatf("tbl%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
            if (vecs[i].flags) begin
                chk($sformatf("tbl%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].c});
                chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].v});
            end
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_done_pulse", i), {30'd0, done, busy}, 32'd0);
        end

        // Start during RUN is ignored and latched operands are undisturbed
        @(negedge clk);
        op = 3'b010; operand_a = 8'h10; operand_b = 8'h20; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 3'b000; operand_a = 8'hFF; operand_b = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ign_alu_op", {29'd0, alu_op}, 32'd2);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("ign_done_seen", {31'd0, done}, 32'd1);
        chk("ign_result", {24'd0, result}, 32'h30);
        @(posedge clk); #1;
        chk("ign_idle_alu_in", {28'd0, alu_a, alu_b, alu_cin, alu_less}, 32'd0);

        // Reset mid-RUN
        @(negedge clk);
        op = 3'b110; operand_a = 8'h55; operand_b = 8'h11; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        @(negedge clk); rst = 1'b0;
        do_op(3'b010, 8'h3C, 8'h05, lat);
        chk("postrst_latency", lat, 10);
        chk("postrst_result", {24'd0, result}, 32'h41);

        // Start held high: DONE ignores it, next IDLE accepts -> one op per 11 cycles
        @(negedge clk);
        op = 3'b010; operand_a = 8'h01; operand_b = 8'h02; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("b2b_first_latency", lat, 10);
        chk("b2b_first_result", {24'd0, result}, 32'h03);
        operand_a = 8'h03; operand_b = 8'h04;
        lat2 = 0;
        do begin @(posedge clk); #1; lat2++; end while (!done && lat2 < 30);
        start = 1'b0;
        chk("b2b_period", lat2, 11);
        chk("b2b_second_result", {24'd0, result}, 32'h07);
        repeat (3) @(posedge clk);

        // Randomized against the word-level model
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        for (int n = 0; n < 40; n++) begin
            logic [2:0] o;
            logic [7:0] a;
            logic [7:0] b;
            o = ops[$urandom_range(0, 7)];
            a = 8'($urandom);
            b = (n % 5 == 0) ? a : 8'($urandom);
            model(o, a, b, mr, mc, mv, mz);
            do_op(o, a, b, lat);
            chk($sformatf("rnd%0d_lat op=%0b", n, o), lat, 10);
            chk($sformatf("rnd%0d_res op=%0b a=%0h b=%0h", n, o, a, b), {24'd0, result}, {24'd0, mr});
            chk($sformatf("rnd%0d_flags op=%0b a=%0h b=%0h", n, o, a, b),
                {29'd0, cout, overflow, zero}, {29'd0, mc, mv, mz});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
